popcnt_arbiter: RTL and testbench

POPCNT_ARBITER -- requirements
Module: popcnt_arbiter

---
 rtl/popcnt_arbiter.sv | 149 ++++++++++++++
 tb/tb_popcnt_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_arbiter.sv
// rtl/popcnt_arbiter.sv - round-robin arbiter feeding a shared popcount engine
module popcnt_arbiter #(
   parameter int WIDTH   = 12,
   parameter int REQS    = 4,
   parameter int TIMEOUT = 64,
   localparam int CW     = $clog2(WIDTH + 1),
   localparam int IW     = $clog2(REQS)
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic [REQS-1:0]       req_i,
   input  logic [REQS*WIDTH-1:0] data_i,
   output logic [REQS-1:0]       ack_o,
   output logic [CW-1:0]         res_o,
   output logic [REQS-1:0]       res_val_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic [WIDTH-1:0]      eng_data_o,
   output logic                  eng_val_o,
   input  logic [CW-1:0]         eng_data_i,
   input  logic                  eng_val_i
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_REQ = IW'(REQS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            state, nxt_state;
   logic [IW-1:0]     ptr, nxt_ptr;
   logic [IW-1:0]     gnt, nxt_gnt;
   logic [WIDTH-1:0]  word, nxt_word;
   logic [TW-1:0]     cnt, nxt_cnt;
   logic [CW-1:0]     res, nxt_res;
   logic              err, nxt_err;

   logic              found;
   logic [IW-1:0]     pick;
   logic [WIDTH-1:0]  pick_word;
   int                idx;

   // Search for the first active request at or after the round-robin pointer
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = 0;
      for (int i = 0; i < REQS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= REQS) idx = idx - REQS;
         if (!found && req_i[IW'(idx)]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   // Select the data word belonging to the candidate requester
   always_comb begin
      pick_word = '0;
      for (int k = 0; k < REQS; k++) begin
         if (pick == IW'(k)) pick_word = data_i[k*WIDTH +: WIDTH];
      end
   end

   // Next-state and datapath update decisions
   always_comb begin
      nxt_state = state;
      nxt_ptr   = ptr;
      nxt_gnt   = gnt;
      nxt_word  = word;
      nxt_cnt   = cnt;
      nxt_res   = res;
      nxt_err   = err;
      case (state)
         ST_IDLE: begin
            if (found) begin
               nxt_gnt   = pick;
               nxt_word  = pick_word;
               nxt_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            nxt_cnt   = '0;
            nxt_state = ST_WAIT;
         end
         ST_WAIT: begin
            // A result landing on the final count still wins over the timeout
            if (eng_val_i) begin
               nxt_res   = eng_data_i;
               nxt_err   = 1'b0;
               nxt_state = ST_RESP;
            end else if (cnt == CNT_LAST) begin
               nxt_res   = '0;
               nxt_err   = 1'b1;
               nxt_state = ST_RESP;
            end else begin
               nxt_cnt = cnt + TW'(1);
            end
         end
         ST_RESP: begin
            nxt_ptr   = (gnt == LAST_REQ) ? '0 : gnt + IW'(1);
            nxt_state = ST_IDLE;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= ST_IDLE;
         ptr   <= '0;
         gnt   <= '0;
         word  <= '0;
         cnt   <= '0;
         res   <= '0;
         err   <= 1'b0;
      end else begin
         state <= nxt_state;
         ptr   <= nxt_ptr;
         gnt   <= nxt_gnt;
         word  <= nxt_word;
         cnt   <= nxt_cnt;
         res   <= nxt_res;
         err   <= nxt_err;
      end
   end

   // Pulses decoded from state; ack is gated by reset because it follows req_i
   always_comb begin
      ack_o     = '0;
      res_val_o = '0;
      if (state == ST_IDLE && found && !arst_i) ack_o[pick] = 1'b1;
      if (state == ST_RESP) res_val_o[gnt] = 1'b1;
   end

   assign busy_o     = (state != ST_IDLE);
   assign eng_val_o  = (state == ST_ISSUE);
   assign eng_data_o = eng_val_o ? word : '0;
   assign res_o      = (state == ST_RESP) ? res : '0;
   assign err_o      = (state == ST_RESP) && err;

endmodule

// File: tb/tb_popcnt_arbiter.sv
// tb/tb_popcnt_arbiter.sv - scoreboard bench for popcnt_arbiter
module tb_popcnt_arbiter;

   localparam int WIDTH   = 12;
   localparam int REQS    = 4;
   localparam int TIMEOUT = 64;
   localparam int CW      = $clog2(WIDTH + 1);

   logic                  clk = 1'b0;
   logic                  arst_i = 1'b1;
   logic [REQS-1:0]       req_i = '0;
   logic [REQS*WIDTH-1:0] data_i = '0;
   logic [REQS-1:0]       ack_o;
   logic [CW-1:0]         res_o;
   logic [REQS-1:0]       res_val_o;
   logic                  err_o;
   logic                  busy_o;
   logic [WIDTH-1:0]      eng_data_o;
   logic                  eng_val_o;
   logic [CW-1:0]         eng_data_i = '0;
   logic                  eng_val_i = 1'b0;

   popcnt_arbiter #(.WIDTH(WIDTH), .REQS(REQS), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .arst_i(arst_i), .req_i(req_i), .data_i(data_i),
      .ack_o(ack_o), .res_o(res_o), .res_val_o(res_val_o), .err_o(err_o),
      .busy_o(busy_o), .eng_data_o(eng_data_o), .eng_val_o(eng_val_o),
      .eng_data_i(eng_data_i), .eng_val_i(eng_val_i)
   );

   typedef struct { longint due; logic [CW-1:0] d; } eng_t;
   typedef struct { int g; logic [CW-1:0] r; logic e; } exp_t;

   int checks = 0;
   int errors = 0;
   longint cyc = 0;
   int model_ptr = 0;
   int eng_lat = 1;
   bit eng_mute = 0;
   bit mon_en = 0;
   eng_t eng_q[$];
   exp_t res_q[$];
   int ack_q[$];
   int ack_seen = 0;
   int res_seen = 0;
   longint last_ack_cyc = 0;
   longint last_res_cyc = 0;
   logic [WIDTH-1:0] words [REQS];

   initial forever #5 clk = ~clk;

   // engine model: captures on eng_val_o, answers eng_lat cycles after capture
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      eng_val_i = 1'b0;
      eng_data_i = '0;
      if (eng_q.size() > 0 && eng_q[0].due <= cyc) begin
         eng_val_i = 1'b1;
         eng_data_i = eng_q[0].d;
         void'(eng_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (eng_val_o === 1'b1 && !eng_mute)
         eng_q.push_back('{cyc + 1 + eng_lat, CW'($countones(eng_data_o))});
   end

   // scoreboard monitor
   always @(negedge clk) begin
      logic [REQS-1:0] ev;
      if (mon_en) begin
         if (ack_o !== '0) begin
            checks++;
            if (ack_q.size() == 0) begin
               errors++;
               $display("FAIL ack_unexpected got %b", ack_o);
            end else begin
               int g;
               g = ack_q.pop_front();
               ev = '0; ev[g] = 1'b1;
               if (ack_o !== ev) begin
                  errors++;
                  $display("FAIL ack_order got %b want %b", ack_o, ev);
               end
            end
            ack_seen++;
            last_ack_cyc = cyc;
         end
         if (res_val_o !== '0) begin
            checks++;
            if (res_q.size() == 0) begin
               errors++;
               $display("FAIL res_unexpected got res_val=%b res=%0d", res_val_o, res_o);
            end else begin
               exp_t e;
               e = res_q.pop_front();
               ev = '0; ev[e.g] = 1'b1;
               if (res_val_o !== ev || res_o !== e.r || err_o !== e.e) begin
                  errors++;
                  $display("FAIL result got val=%b res=%0d err=%b want val=%b res=%0d err=%b",
                           res_val_o, res_o, err_o, ev, e.r, e.e);
               end
            end
            res_seen++;
            last_res_cyc = cyc;
         end else begin
            checks++;
            if (res_o !== '0 || err_o !== 1'b0) begin
               errors++;
               $display("FAIL idle_res got res=%0d err=%b want 0 0", res_o, err_o);
            end
         end
         if (eng_val_o !== 1'b1) begin
            checks++;
            if (eng_data_o !== '0) begin
               errors++;
               $display("FAIL idle_eng_data got %h want 0", eng_data_o);
            end
         end
      end
   end

   task automatic set_word(input int k, input logic [WIDTH-1:0] w);
      words[k] = w;
      data_i[k*WIDTH +: WIDTH] = w;
   endtask

   // predicts the grant for mask m, records expectations, advances model pointer
   task automatic expect_txn(input logic [REQS-1:0] m, input bit timeout, output int g);
      g = -1;
      for (int i = 0; i < REQS; i++) begin
         int j;
         j = (model_ptr + i) % REQS;
         if (g < 0 && m[j]) g = j;
      end
      ack_q.push_back(g);
      if (timeout) res_q.push_back('{g, '0, 1'b1});
      else res_q.push_back('{g, CW'($countones(words[g])), 1'b0});
      model_ptr = (g + 1) % REQS;
   endtask

   task automatic wait_ack(input int budget, output bit ok);
      int start;
      start = ack_seen;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (ack_seen != start) begin ok = 1; break; end
      end
   endtask

   task automatic wait_res(input int target, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (res_seen >= target) begin ok = 1; break; end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_reset();
      arst_i = 1'b1;
      req_i = '1;
      data_i = {$urandom, $urandom};
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({ack_o, res_val_o, res_o, err_o, busy_o, eng_val_o, eng_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ack=%b rv=%b res=%0d err=%b busy=%b ev=%b ed=%h want all 0",
                  ack_o, res_val_o, res_o, err_o, busy_o, eng_val_o, eng_data_o);
      end
      @(posedge clk); #1;
      req_i = '0;
      arst_i = 1'b0;
      model_ptr = 0;
      mon_en = 1;
      @(negedge clk); #1;
      checks++;
      if (busy_o !== 1'b0 || ack_o !== '0) begin
         errors++;
         $display("FAIL post_reset_idle got busy=%b ack=%b want 0 0", busy_o, ack_o);
      end
   endtask

   task automatic test_single();
      int g, base;
      bit ok;
      longint t;
      base = res_seen;
      @(posedge clk); #1;
      eng_lat = 1;
      set_word(0, 12'hFFF);
      req_i = 4'b0001;
      expect_txn(req_i, 0, g);
      wait_ack(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_ack got none want ack within 20"); end
      t = last_ack_cyc;
      @(posedge clk); #1;
      req_i = '0;
      @(negedge clk); #1;
      checks++;
      if (eng_val_o !== 1'b1 || eng_data_o !== 12'hFFF || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL single_issue got ev=%b ed=%h busy=%b want 1 fff 1", eng_val_o, eng_data_o, busy_o);
      end
      wait_res(base + 1, 30, ok);
      checks++;
      if (!ok || last_res_cyc - t != 4) begin
         errors++;
         $display("FAIL single_latency got %0d want 4", last_res_cyc - t);
      end
   endtask

   task automatic test_rotation();
      int g, base;
      bit ok;
      @(posedge clk); #1;
      arst_i = 1'b1;
      @(posedge clk); #1;
      arst_i = 1'b0;
      model_ptr = 0;
      base = res_seen;
      eng_lat = 2;
      set_word(0, 12'h001); set_word(1, 12'h003);
      set_word(2, 12'h007); set_word(3, 12'h00F);
      req_i = 4'b1111;
      for (int n = 0; n < 5; n++) expect_txn(req_i, 0, g);
      for (int n = 0; n < 5; n++) begin
         wait_ack(40, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rotation_ack got none want ack %0d", n); break; end
      end
      @(posedge clk); #1;
      req_i = '0;
      wait_res(base + 5, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rotation_results got %0d want %0d", res_seen - base, 5); end
   endtask

   task automatic test_timeout();
      int g, base;
      bit ok;
      longint t;
      logic [REQS-1:0] masks [3];
      int lats [3];
      bit tos [3];
      masks[0] = 4'b0100; lats[0] = 1;  tos[0] = 1;
      masks[1] = 4'b0001; lats[1] = 63; tos[1] = 0;
      masks[2] = 4'b0010; lats[2] = 64; tos[2] = 1;
      set_word(0, 12'h5A5); set_word(1, 12'h7F0); set_word(2, 12'hABC);
      for (int n = 0; n < 3; n++) begin
         base = res_seen;
         @(posedge clk); #1;
         eng_mute = (n == 0);
         eng_lat = lats[n];
         req_i = masks[n];
         expect_txn(req_i, tos[n], g);
         wait_ack(20, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL timeout_ack case %0d got none", n); end
         t = last_ack_cyc;
         @(posedge clk); #1;
         req_i = '0;
         wait_res(base + 1, 120, ok);
         checks++;
         if (!ok || last_res_cyc - t != 66) begin
            errors++;
            $display("FAIL timeout_latency case %0d got %0d want 66", n, last_res_cyc - t);
         end
         repeat (3) @(posedge clk);
      end
      eng_mute = 0;
   endtask

   task automatic test_back_to_back();
      int g, base;
      bit ok;
      longint r1;
      base = res_seen;
      @(posedge clk); #1;
      eng_lat = 3;
      set_word(0, 12'h0F3); set_word(1, 12'h111); set_word(2, 12'h3C0);
      req_i = 4'b0001;
      expect_txn(req_i, 0, g);
      wait_ack(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_ack1 got none"); end
      @(posedge clk); #1;
      req_i = 4'b0110;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_i = 4'b0100;
      expect_txn(req_i, 0, g);
      wait_res(base + 1, 30, ok);
      r1 = last_res_cyc;
      wait_ack(20, ok);
      checks++;
      if (!ok || last_ack_cyc - r1 != 1) begin
         errors++;
         $display("FAIL b2b_next_idle_grant got %0d want 1", last_ack_cyc - r1);
      end
      @(posedge clk); #1;
      req_i = '0;
      wait_res(base + 2, 30, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_results got %0d want 2", res_seen - base); end
   endtask

   task automatic test_reset_mid();
      int g, base;
      bit ok;
      longint t;
      @(posedge clk); #1;
      eng_lat = 5;
      set_word(1, 12'hFFF);
      req_i = 4'b0010;
      expect_txn(req_i, 0, g);
      void'(res_q.pop_back());
      wait_ack(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rmid_ack got none"); end
      @(posedge clk); #1;
      req_i = '0;
      repeat (3) @(negedge clk);
      #2;
      arst_i = 1'b1;
      req_i = 4'b1111;
      #1;
      checks++;
      if ({ack_o, res_val_o, res_o, err_o, busy_o, eng_val_o, eng_data_o} !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got ack=%b rv=%b res=%0d err=%b busy=%b ev=%b ed=%h want all 0",
                  ack_o, res_val_o, res_o, err_o, busy_o, eng_val_o, eng_data_o);
      end
      @(posedge clk); #1;
      req_i = '0;
      arst_i = 1'b0;
      model_ptr = 0;
      base = res_seen;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (res_seen != base) begin errors++; $display("FAIL rmid_late_eng got %0d results want 0", res_seen - base); end
      set_word(3, 12'h0F0);
      req_i = 4'b1000;
      expect_txn(req_i, 0, g);
      wait_ack(20, ok);
      t = last_ack_cyc;
      checks++;
      if (!ok) begin errors++; $display("FAIL rmid_regrant got none want ack 1000"); end
      @(posedge clk); #1;
      req_i = '0;
      wait_res(base + 1, 30, ok);
      checks++;
      if (!ok || last_res_cyc - t != 8) begin
         errors++;
         $display("FAIL rmid_latency got %0d want 8", last_res_cyc - t);
      end
   endtask

   task automatic test_random();
      int g, base, n_txn;
      bit ok;
      logic [REQS-1:0] pending, add;
      base = res_seen;
      n_txn = 1500;
      pending = '0;
      for (int n = 0; n < n_txn; n++) begin
         @(posedge clk); #1;
         add = REQS'($urandom);
         if ((pending | add) == '0) add[$urandom_range(0, REQS-1)] = 1'b1;
         for (int k = 0; k < REQS; k++)
            if (add[k] && !pending[k]) set_word(k, WIDTH'($urandom));
         pending = pending | add;
         eng_lat = $urandom_range(1, 10);
         req_i = pending;
         expect_txn(pending, 0, g);
         wait_ack(200, ok);
         if (!ok) begin
            checks++; errors++;
            $display("FAIL random_ack txn %0d got none", n);
            break;
         end
         @(posedge clk); #1;
         pending[g] = 1'b0;
         req_i = pending;
      end
      req_i = '0;
      wait_res(base + n_txn, 500, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL random_results got %0d want %0d", res_seen - base, n_txn); end
   endtask

   initial begin
      for (int k = 0; k < REQS; k++) words[k] = '0;
      test_reset();
      test_single();
      test_rotation();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (res_q.size() != 0 || ack_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got res_q=%0d ack_q=%0d want 0 0", res_q.size(), ack_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
